fx2_ep6_stream_tx: RTL and testbench

- Streaming transmitter toward the host: accepts bytes from an upstream processing block (e.g. FFT output) over a valid/ready handshake and buffers them in an internal circular byte buffer.
- Writes the bytes into FX2 slave FIFO6 (EP6 IN) in positive logic. Full packets auto-commit; short packets are committed with PKTEND on flush or idle timeout.
- Sits between the datapath and the FX2 pin-level inversion logic. Shares the FX2 bus with the EP2 reader through a req/gnt pair.

---
 rtl/fx2_ep6_stream_tx.sv | 151 +++++++++++++++
 tb/tb_fx2_ep6_stream_tx.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_ep6_stream_tx.sv
// EP6 IN streaming writer: buffers upstream bytes and writes them into FX2 slave FIFO6.
// Define FX2_ZLP_EN to let flushes with no pending data emit zero-length packets.
`timescale 1ns/1ps
module fx2_ep6_stream_tx #(
    parameter int unsigned BUF_AW   = 9,
    parameter int unsigned PKT_SIZE = 512,
    parameter int unsigned TIMEOUT  = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              bus_req,
    input  logic              bus_gnt,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic              fifo_pktend,
    output logic [7:0]        fifo_dataout,
    output logic              fifo_dataout_oe,
    output logic [1:0]        fifo_fifoadr,
    output logic [BUF_AW:0]   level,
    output logic [15:0]       pkt_count
);

    localparam int unsigned DEPTH = 1 << BUF_AW;
    localparam int unsigned TW    = $clog2(TIMEOUT + 2);
    localparam logic [10:0] PKT_LAST   = 11'(PKT_SIZE - 1);
    localparam logic [BUF_AW:0] FULL_LEVEL = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [BUF_AW:0] ONE_LEVEL  = {{BUF_AW{1'b0}}, 1'b1};
`ifdef FX2_ZLP_EN
    localparam bit ZLP_EN = 1'b1;
`else
    localparam bit ZLP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StTurn, StWrite, StPktend} state_e;

    state_e            state_q;
    logic [7:0]        mem [DEPTH];
    logic [BUF_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [BUF_AW:0]   level_q;
    logic [10:0]       pkt_bytes_q;
    logic              pend_end_q;
    logic [TW-1:0]     idle_cnt_q;
    logic [15:0]       pkt_count_q;
    logic              oe_q;
    logic [1:0]        adr_q;

    logic push, pop, buf_empty, auto_commit, drained_on_commit;
    logic flush_set, timeout_set, stale_pend, idle_tick;

    assign buf_empty    = (level_q == '0);
    assign in_ready     = (level_q != FULL_LEVEL);
    assign push         = in_valid & in_ready;
    assign fifo_wr      = (state_q == StWrite) & bus_gnt & ~fifo_full & ~buf_empty;
    assign fifo_pktend  = (state_q == StPktend) & ~fifo_full;
    assign pop          = fifo_wr;
    assign fifo_dataout = mem[rd_ptr_q];
    assign fifo_dataout_oe = oe_q;
    assign fifo_fifoadr = adr_q;
    assign level        = level_q;
    assign pkt_count    = pkt_count_q;
    assign bus_req      = (state_q != StIdle) | ~buf_empty | pend_end_q;

    assign auto_commit       = pop & (pkt_bytes_q == PKT_LAST);
    // A full packet that drains the buffer already committed everything pending.
    assign drained_on_commit = auto_commit & (level_q == ONE_LEVEL) & ~push;
    assign flush_set   = flush & (ZLP_EN | ~buf_empty | ((pkt_bytes_q != '0) & ~fifo_pktend));
    assign idle_tick   = ~in_valid & buf_empty & (pkt_bytes_q != '0);
    assign timeout_set = (TIMEOUT != 0) & (idle_cnt_q == TW'(TIMEOUT)) & ~fifo_pktend;
    // Without ZLP support a pending end with nothing in the packet has nothing to commit.
    assign stale_pend  = (state_q == StWrite) & bus_gnt & buf_empty & pend_end_q
                         & (pkt_bytes_q == '0) & ~ZLP_EN;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pkt_bytes_q <= '0;
            pend_end_q  <= 1'b0;
            idle_cnt_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + ONE_LEVEL;
                2'b01:   level_q <= level_q - ONE_LEVEL;
                default: level_q <= level_q;
            endcase

            if (auto_commit || fifo_pktend) pkt_bytes_q <= '0;
            else if (pop)                   pkt_bytes_q <= pkt_bytes_q + 11'd1;

            if (auto_commit || fifo_pktend) pkt_count_q <= pkt_count_q + 16'd1;

            if (flush_set || timeout_set)
                pend_end_q <= 1'b1;
            else if (fifo_pktend || stale_pend || (drained_on_commit && !ZLP_EN))
                pend_end_q <= 1'b0;

            if (!idle_tick)                       idle_cnt_q <= '0;
            else if (idle_cnt_q != TW'(TIMEOUT))  idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            oe_q    <= 1'b0;
            adr_q   <= 2'b00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_req && bus_gnt) begin
                        state_q <= StTurn;
                        oe_q    <= 1'b1;
                        adr_q   <= 2'b10;
                    end
                end
                StTurn: state_q <= StWrite;
                StWrite: begin
                    if (!bus_gnt || (buf_empty && !(pend_end_q && ((pkt_bytes_q != '0) || ZLP_EN))))
                    begin
                        state_q <= StIdle;
                        oe_q    <= 1'b0;
                        adr_q   <= 2'b00;
                    end else if (buf_empty) begin
                        state_q <= StPktend;
                    end
                end
                StPktend: begin
                    if (!fifo_full) begin
                        state_q <= StIdle;
                        oe_q    <= 1'b0;
                        adr_q   <= 2'b00;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fx2_ep6_stream_tx.sv
// Scoreboard bench for fx2_ep6_stream_tx: pushed bytes are queued and matched against FIFO writes.
`timescale 1ns/1ps
module tb_fx2_ep6_stream_tx;

    localparam int BUF_AW = 9;
    localparam int PKT    = 512;
    localparam int TMO    = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              flush = 1'b0;
    logic              bus_req;
    logic              bus_gnt = 1'b0;
    logic              fifo_full = 1'b0;
    logic              fifo_wr;
    logic              fifo_pktend;
    logic [7:0]        fifo_dataout;
    logic              fifo_dataout_oe;
    logic [1:0]        fifo_fifoadr;
    logic [BUF_AW:0]   level;
    logic [15:0]       pkt_count;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int pktend_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic       prev_oe = 1'b0;

    fx2_ep6_stream_tx #(.BUF_AW(BUF_AW), .PKT_SIZE(PKT), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_pktend(fifo_pktend),
        .fifo_dataout(fifo_dataout), .fifo_dataout_oe(fifo_dataout_oe),
        .fifo_fifoadr(fifo_fifoadr), .level(level), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // Write monitor: pops the scoreboard and checks bus ownership on every write.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_oe = 1'b0;
            end else begin
                if (fifo_wr) begin
                    wr_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL wr_data: got write of %02h, required no write", fifo_dataout);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (fifo_dataout !== exp_b) begin
                            failures++;
                            $display("FAIL wr_data: got %02h required %02h", fifo_dataout, exp_b);
                        end
                    end
                    checks++;
                    if (!bus_gnt || fifo_full || fifo_fifoadr !== 2'b10 || !fifo_dataout_oe
                        || !prev_oe || fifo_pktend) begin
                        failures++;
                        $display("FAIL wr_protocol: got gnt=%b full=%b adr=%b oe=%b prev_oe=%b pktend=%b, required 1 0 10 1 1 0",
                                 bus_gnt, fifo_full, fifo_fifoadr, fifo_dataout_oe, prev_oe, fifo_pktend);
                    end
                end
                if (fifo_pktend) pktend_cnt++;
                prev_oe = fifo_dataout_oe;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish before 500us");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        bus_gnt = 1'b0;
        fifo_full = 1'b0;
        in_data = 8'h00;
        repeat (2) tick();
        exp_q.delete();
        wr_cnt = 0;
        pktend_cnt = 0;
        reset = 1'b0;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        while (!in_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_wait: got in_ready=0 after %0d cycles, required 1", n);
        end else begin
            exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int max_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (!(level == '0 && !bus_req) && n < max_cycles) begin
            n++;
            @(negedge clk);
        end
        if (!(level == '0 && !bus_req)) begin
            checks++;
            failures++;
            $display("FAIL quiet_wait: got level=%0d bus_req=%b, required 0 0", level, bus_req);
        end
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({fifo_wr, fifo_pktend, fifo_dataout_oe, fifo_fifoadr, bus_req, in_ready} !== 7'b0000001)
        begin
            failures++;
            $display("FAIL reset_ctrl: got wr,pktend,oe,adr,req,ready=%b required 0000001",
                     {fifo_wr, fifo_pktend, fifo_dataout_oe, fifo_fifoadr, bus_req, in_ready});
        end
        checks++;
        if (level !== '0) begin
            failures++;
            $display("FAIL reset_level: got %0d required 0", level);
        end
        checks++;
        if (pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_pkt_count: got %0d required 0", pkt_count);
        end
    endtask

    task automatic test_stream();
        do_reset();
        bus_gnt = 1'b1;
        for (int i = 0; i < 512; i++) push_byte(8'(i));
        wait_quiet(200);
        repeat (30) tick();
        checks++;
        if (wr_cnt != 512) begin
            failures++;
            $display("FAIL stream_writes: got %0d required 512", wr_cnt);
        end
        checks++;
        if (pktend_cnt != 0) begin
            failures++;
            $display("FAIL stream_pktend: got %0d required 0", pktend_cnt);
        end
        checks++;
        if (pkt_count !== 16'd1 || level !== '0) begin
            failures++;
            $display("FAIL stream_counts: got pkt_count=%0d level=%0d required 1 0", pkt_count, level);
        end
    endtask

    task automatic test_flush();
        int n;
        do_reset();
        bus_gnt = 1'b1;
        for (int i = 0; i < 3; i++) push_byte(8'hA1 + 8'(i));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        @(negedge clk);
        while (!fifo_pktend && n < 100) begin
            n++;
            @(negedge clk);
        end
        repeat (5) tick();
        checks++;
        if (wr_cnt != 3 || pktend_cnt != 1) begin
            failures++;
            $display("FAIL flush_strobes: got writes=%0d pktend=%0d required 3 1", wr_cnt, pktend_cnt);
        end
        checks++;
        if (pkt_count !== 16'd1 || bus_req || fifo_dataout_oe) begin
            failures++;
            $display("FAIL flush_idle: got pkt_count=%0d req=%b oe=%b required 1 0 0",
                     pkt_count, bus_req, fifo_dataout_oe);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        bus_gnt = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
        n = 0;
        @(negedge clk);
        while (level != '0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (!fifo_pktend && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n < TMO || n > TMO + 8) begin
            failures++;
            $display("FAIL timeout_delay: got pktend %0d cycles after drain, required %0d..%0d",
                     n, TMO, TMO + 8);
        end
        repeat (5) tick();
        checks++;
        if (wr_cnt != 5 || pktend_cnt != 1 || pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL timeout_counts: got writes=%0d pktend=%0d pkt_count=%0d required 5 1 1",
                     wr_cnt, pktend_cnt, pkt_count);
        end
    endtask

    task automatic test_stall();
        int w;
        do_reset();
        for (int i = 0; i < 40; i++) push_byte(8'h40 + 8'(i));
        bus_gnt = 1'b1;
        repeat (8) tick();
        fifo_full = 1'b1;
        w = wr_cnt;
        repeat (10) tick();
        checks++;
        if (wr_cnt != w || w == 0) begin
            failures++;
            $display("FAIL stall_full: got writes before=%0d after=%0d, required before>0 and equal",
                     w, wr_cnt);
        end
        fifo_full = 1'b0;
        repeat (3) tick();
        bus_gnt = 1'b0;
        w = wr_cnt;
        repeat (3) tick();
        checks++;
        if (wr_cnt != w || fifo_dataout_oe !== 1'b0) begin
            failures++;
            $display("FAIL stall_nognt: got writes %0d->%0d oe=%b, required no writes, oe=0",
                     w, wr_cnt, fifo_dataout_oe);
        end
        bus_gnt = 1'b1;
        wait_quiet(200);
        checks++;
        if (wr_cnt != 40 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_total: got writes=%0d left=%0d required 40 0", wr_cnt, exp_q.size());
        end
    endtask

    task automatic test_fill();
        int lv, both;
        logic pu, po;
        do_reset();
        for (int i = 0; i < 512; i++) push_byte(8'(i) ^ 8'h5A);
        @(negedge clk);
        checks++;
        if (level !== 10'd512 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got level=%0d ready=%b required 512 0", level, in_ready);
        end
        in_valid = 1'b1;
        in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        checks++;
        if (level !== 10'd512) begin
            failures++;
            $display("FAIL fill_blocked: got level=%0d required 512", level);
        end
        bus_gnt = 1'b1;
        repeat (6) tick();
        both = 0;
        for (int k = 0; k < 30; k++) begin
            in_valid = 1'b1;
            in_data = 8'hC0 + 8'(k);
            @(negedge clk);
            lv = int'(level);
            pu = in_ready;
            po = fifo_wr;
            if (pu) exp_q.push_back(in_data);
            if (pu && po) both++;
            @(posedge clk);
            #1;
            checks++;
            if (int'(level) != lv + int'(pu) - int'(po)) begin
                failures++;
                $display("FAIL fill_level: got %0d required %0d", level, lv + int'(pu) - int'(po));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (both == 0) begin
            failures++;
            $display("FAIL fill_simul: got 0 push+pop cycles, required at least 1");
        end
        wait_quiet(2000);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL fill_drain: got %0d bytes left, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 100; i++) push_byte(8'(i) + 8'h07);
        bus_gnt = 1'b1;
        repeat (5) tick();
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({fifo_wr, fifo_pktend, fifo_dataout_oe, fifo_fifoadr, bus_req} !== 6'b0
            || level !== '0 || pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid: got wr,pktend,oe,adr,req=%b level=%0d pkt_count=%0d required 0 0 0",
                     {fifo_wr, fifo_pktend, fifo_dataout_oe, fifo_fifoadr, bus_req}, level, pkt_count);
        end
        exp_q.delete();
        wr_cnt = 0;
        pktend_cnt = 0;
        tick();
        reset = 1'b0;
        repeat (50) tick();
        checks++;
        if (wr_cnt != 0 || pktend_cnt != 0 || level !== '0) begin
            failures++;
            $display("FAIL reset_mid_after: got writes=%0d pktend=%0d level=%0d required 0 0 0",
                     wr_cnt, pktend_cnt, level);
        end
    endtask

    task automatic test_empty_flush();
        int exp_pe;
        do_reset();
        bus_gnt = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (20) tick();
`ifdef FX2_ZLP_EN
        exp_pe = 1;
`else
        exp_pe = 0;
`endif
        checks++;
        if (wr_cnt != 0 || pktend_cnt != exp_pe || int'(pkt_count) != exp_pe) begin
            failures++;
            $display("FAIL empty_flush: got writes=%0d pktend=%0d pkt_count=%0d required 0 %0d %0d",
                     wr_cnt, pktend_cnt, pkt_count, exp_pe, exp_pe);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_flush();
        test_timeout();
        test_stall();
        test_fill();
        test_reset_mid();
        test_empty_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
